// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   IDLE / CLEAR : clear-sweep FSM state encodings
//   clog2        : address/select width from an entry or port count (min 1)
//   port_lo      : low bit of port <port> inside a packed multi-port bus
package regfile_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbitration for regfile_mp (purely combinational).
//   busy    in  : clear sweep running, every write is refused
//   wr_en   in  : per-port write enable
//   wr_addr in  : packed write addresses
//   rd_addr in  : packed read addresses (for bypass matching)
//   commit  out : per-port mask of writes that reach the array
//   drop    out : at least one enabled write was discarded
//   byp_hit out : per read port, a committed write targets its address
//   byp_sel out : packed per read port, index of that committing write port
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 0,
  parameter int SEL_W    = 1
) (
  input  logic                  busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NWR-1:0]        commit,
  output logic                  drop,
  output logic [NRD-1:0]        byp_hit,
  output logic [NRD*SEL_W-1:0]  byp_sel
);

  logic [ADDR_W-1:0] wa [NWR];
  logic [ADDR_W-1:0] ra [NRD];
  logic [NWR-1:0]    in_range;
  logic [NWR-1:0]    storable;
  logic [NWR-1:0]    lost;

  always_comb begin
    for (int i = 0; i < NWR; i++) wa[i] = wr_addr[port_lo(i, ADDR_W) +: ADDR_W];
    for (int r = 0; r < NRD; r++) ra[r] = rd_addr[port_lo(r, ADDR_W) +: ADDR_W];
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loops below can leave a value unassigned (no latches).
  always_comb begin
    in_range = '0;
    storable = '0;
    lost     = '0;
    commit   = '0;
    drop     = 1'b0;
    byp_hit  = '0;
    byp_sel  = '0;

    // Writes to the hardwired zero entry vanish silently: they neither
    // commit nor take part in conflicts, so they never raise drop.
    for (int i = 0; i < NWR; i++) begin
      in_range[i] = int'(wa[i]) < DEPTH;
      storable[i] = wr_en[i] && in_range[i] && !((ZERO_REG != 0) && (wa[i] == '0));
    end

    // Lowest-numbered port wins a same-address conflict.
    for (int i = 1; i < NWR; i++)
      for (int j = 0; j < i; j++)
        if (storable[i] && storable[j] && (wa[j] == wa[i])) lost[i] = 1'b1;

    if (busy) begin
      drop = |wr_en;
    end else begin
      commit = storable & ~lost;
      drop   = (|(wr_en & ~in_range)) || (|lost);
    end

    // Committed addresses are distinct, so at most one port can match.
    for (int r = 0; r < NRD; r++)
      for (int i = NWR - 1; i >= 0; i--)
        if (commit[i] && (wa[i] == ra[r])) begin
          byp_hit[r]                           = 1'b1;
          byp_sel[port_lo(r, SEL_W) +: SEL_W] = SEL_W'(i);
        end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, write
// conflict arbitration, optional write-to-read bypass, optional hardwired
// zero entry and a self-sequencing clear sweep.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clr        : start (or restart) a clear sweep
//   busy       : clear sweep running; reads and writes are refused
//   wr_en/wr_addr/wr_data : NWR packed write ports
//   wr_drop    : registered, an enabled write was discarded last cycle
//   rd_en/rd_addr         : NRD packed read ports
//   rd_data/rd_valid      : registered read results, one cycle latency
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic                  wr_drop,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid
);

  localparam int SEL_W = clog2(NWR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]          state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [NWR-1:0]      commit;
  logic                drop;
  logic [NRD-1:0]      byp_hit;
  logic [NRD*SEL_W-1:0] byp_sel;
  logic [NRD*DATA_W-1:0] rd_next;

  assign busy = (state == CLEAR);

  regfile_wr_arb #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR),
    .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
  ) u_arb (
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .commit  (commit),
    .drop    (drop),
    .byp_hit (byp_hit),
    .byp_sel (byp_sel)
  );

  // Clear sweep: reset and clr both (re)start at entry 0; the sweep ends
  // on the edge that clears entry DEPTH-1.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (clr) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      if (ptr == LAST) begin
        state <= IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end

  // NOTE: the array has no reset branch so it maps onto plain storage; the
  // clear sweep is what brings it to zero.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (commit[i])
          mem[wr_addr[port_lo(i, ADDR_W) +: ADDR_W]] <= wr_data[port_lo(i, DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    rd_next = '0;
    for (int r = 0; r < NRD; r++) begin
      logic [ADDR_W-1:0] a;
      logic [SEL_W-1:0]  s;
      a = rd_addr[port_lo(r, ADDR_W) +: ADDR_W];
      s = byp_sel[port_lo(r, SEL_W) +: SEL_W];
      if ((int'(a) >= DEPTH) || ((ZERO_REG != 0) && (a == '0)))
        rd_next[port_lo(r, DATA_W) +: DATA_W] = '0;
      else if ((BYPASS != 0) && byp_hit[r])
        rd_next[port_lo(r, DATA_W) +: DATA_W] = wr_data[port_lo(int'(s), DATA_W) +: DATA_W];
      else
        rd_next[port_lo(r, DATA_W) +: DATA_W] = mem[a];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop  <= drop;
      rd_valid <= '0;
      if (!busy) begin
        for (int r = 0; r < NRD; r++)
          if (rd_en[r]) begin
            rd_valid[r]                           <= 1'b1;
            rd_data[port_lo(r, DATA_W) +: DATA_W] <= rd_next[port_lo(r, DATA_W) +: DATA_W];
          end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Three instances share all stimulus:
//   dut_a : defaults (DEPTH 32, BYPASS 1)
//   dut_b : BYPASS 0
//   dut_c : DEPTH 24, ZERO_REG 1
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 64;

  logic         clk;
  logic         reset;
  logic         clr;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic [3:0]   rd_en;
  logic [19:0]  rd_addr;

  logic         busy_a, busy_b, busy_c;
  logic         wr_drop_a, wr_drop_b, wr_drop_c;
  logic [255:0] rd_data_a, rd_data_b, rd_data_c;
  logic [3:0]   rd_valid_a, rd_valid_b, rd_valid_c;

  regfile_mp dut_a (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  regfile_mp #(.DEPTH(24), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop_c),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0]       wen;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd;
    logic [3:0]       ren;
    logic [3:0][4:0]  ra;
    logic [3:0]       ev;
    logic             ed;
    logic [3:0][63:0] ea;
    logic [3:0][63:0] eb;
  } vec_t;

  function automatic vec_t row(
    input logic [1:0] wen, input logic [4:0] wa0, input logic [63:0] wd0,
    input logic [4:0] wa1, input logic [63:0] wd1,
    input logic [3:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [4:0] ra2, input logic [4:0] ra3,
    input logic [3:0] ev, input logic ed,
    input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
    input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
    vec_t v;
    v.wen = wen; v.wa[0] = wa0; v.wd[0] = wd0; v.wa[1] = wa1; v.wd[1] = wd1;
    v.ren = ren; v.ra[0] = ra0; v.ra[1] = ra1; v.ra[2] = ra2; v.ra[3] = ra3;
    v.ev = ev; v.ed = ed;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2; v.eb[3] = b3;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; wr_en = '0; rd_en = '0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [63:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  // Counts edges taken while busy_a (and busy_c) was high; optional clr
  // pulse on the edge numbered restart_at+1.
  task automatic count_busy(input int restart_at, output int na, output int nc);
    na = 0; nc = 0;
    while (busy_a && na < 100) begin
      logic bc;
      clr = (na == restart_at);
      bc  = busy_c;
      step();
      na++;
      if (bc) nc++;
    end
    clr = 1'b0;
    while (busy_c && nc < 100) begin
      step();
      nc++;
    end
  endtask

  // Reads every entry of dut_a, four per cycle, expecting zero.
  task automatic read_all_zero(input string tag);
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      for (int p = 0; p < 4; p++) set_rd(p, 5'(4 * k + p));
      step();
      check({tag, " rd_valid"}, 64'(rd_valid_a), 64'hF);
      for (int p = 0; p < 4; p++) check({tag, " rd_data"}, rd_data_a[p*DW +: DW], 64'd0);
    end
    idle_inputs();
    step();
    check({tag, " rd_valid drops"}, 64'(rd_valid_a), 64'd0);
  endtask

  vec_t tbl [9];
  int   na, nc;

  initial begin
    tbl[0] = row(2'b11, 0, 100, 1, 200,    4'b0000, 0, 0, 0, 0, 4'b0000, 0,
                 0, 0, 0, 0,                0, 0, 0, 0);
    tbl[1] = row(2'b00, 0, 0, 0, 0,        4'b1111, 0, 1, 0, 1, 4'b1111, 0,
                 100, 200, 100, 200,        100, 200, 100, 200);
    tbl[2] = row(2'b11, 7, 5, 7, 9,        4'b0000, 0, 0, 0, 0, 4'b0000, 1,
                 100, 200, 100, 200,        100, 200, 100, 200);
    tbl[3] = row(2'b00, 0, 0, 0, 0,        4'b0001, 7, 0, 0, 0, 4'b0001, 0,
                 5, 200, 100, 200,          5, 200, 100, 200);
    tbl[4] = row(2'b01, 3, 'hABCD, 0, 0,   4'b0100, 0, 0, 3, 0, 4'b0100, 0,
                 5, 200, 'hABCD, 200,       5, 200, 0, 200);
    tbl[5] = row(2'b00, 0, 0, 0, 0,        4'b0010, 0, 3, 0, 0, 4'b0010, 0,
                 5, 'hABCD, 'hABCD, 200,    5, 'hABCD, 0, 200);
    tbl[6] = row(2'b11, 9, 'h11, 9, 'h22,  4'b1000, 0, 0, 0, 9, 4'b1000, 1,
                 5, 'hABCD, 'hABCD, 'h11,   5, 'hABCD, 0, 0);
    tbl[7] = row(2'b10, 0, 0, 10, 'h44,    4'b0011, 9, 10, 0, 0, 4'b0011, 0,
                 'h11, 'h44, 'hABCD, 'h11,  'h11, 0, 0, 0);
    tbl[8] = row(2'b00, 0, 0, 0, 0,        4'b1111, 10, 9, 3, 0, 4'b1111, 0,
                 'h44, 'h11, 'hABCD, 100,   'h44, 'h11, 'hABCD, 100);

    // Power-on reset and clear sweep.
    reset = 1'b1; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle_inputs();
    step();
    check("reset busy", 64'(busy_a), 64'd1);
    check("reset rd_valid", 64'(rd_valid_a), 64'd0);
    check("reset wr_drop", 64'(wr_drop_a), 64'd0);
    check("reset rd_data p0", rd_data_a[63:0], 64'd0);
    step();
    reset = 1'b0;
    count_busy(-1, na, nc);
    check("power-on sweep cycles A", 64'(na), 64'd32);
    check("power-on sweep cycles C", 64'(nc), 64'd24);
    check("busy_b low after sweep", 64'(busy_b), 64'd0);
    read_all_zero("power-on");

    // Table of single-cycle vectors.
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      wr_en = tbl[i].wen;
      rd_en = tbl[i].ren;
      for (int p = 0; p < 2; p++) begin
        wr_addr[p*AW +: AW] = tbl[i].wa[p];
        wr_data[p*DW +: DW] = tbl[i].wd[p];
      end
      for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = tbl[i].ra[p];
      step();
      check($sformatf("vec%0d rd_valid A", i), 64'(rd_valid_a), 64'(tbl[i].ev));
      check($sformatf("vec%0d rd_valid B", i), 64'(rd_valid_b), 64'(tbl[i].ev));
      check($sformatf("vec%0d wr_drop", i), 64'(wr_drop_a), 64'(tbl[i].ed));
      for (int p = 0; p < 4; p++) begin
        check($sformatf("vec%0d rd_data A p%0d", i, p), rd_data_a[p*DW +: DW], tbl[i].ea[p]);
        check($sformatf("vec%0d rd_data B p%0d", i, p), rd_data_b[p*DW +: DW], tbl[i].eb[p]);
      end
    end

    // Clear sweep under write/read traffic.
    idle_inputs();
    clr = 1'b1;
    check("busy before clr edge", 64'(busy_a), 64'd0);
    step();
    clr = 1'b0;
    check("busy after clr edge", 64'(busy_a), 64'd1);
    na = 0;
    while (busy_a && na < 100) begin
      set_wr(0, 2, 'h77);
      set_wr(1, 4, 'h88);
      for (int p = 0; p < 4; p++) set_rd(p, 5'(p));
      step();
      na++;
      check("sweep wr_drop", 64'(wr_drop_a), 64'd1);
      check("sweep rd_valid", 64'(rd_valid_a), 64'd0);
      check("sweep rd_data hold p0", rd_data_a[63:0], 64'h44);
      check("sweep rd_data hold p2", rd_data_a[191:128], 64'hABCD);
    end
    check("traffic sweep cycles", 64'(na), 64'd32);
    idle_inputs();
    step();
    check("wr_drop clears after sweep", 64'(wr_drop_a), 64'd0);
    read_all_zero("after clear");

    // Restart a sweep with clr while it runs.
    idle_inputs();
    set_wr(0, 5, 'h5A);
    step();
    idle_inputs();
    for (int p = 0; p < 4; p++) set_rd(p, 5);
    step();
    check("readback 0x5A", rd_data_a[255:192], 64'h5A);
    idle_inputs();
    clr = 1'b1;
    step();
    count_busy(9, na, nc);
    check("restarted sweep cycles A", 64'(na), 64'd42);
    check("restarted sweep cycles C", 64'(nc), 64'd34);

    // Reset in the middle of a sweep.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
    check("pre-reset rd_data held", rd_data_a[63:0], 64'h5A);
    reset = 1'b1;
    #1;
    check("mid-sweep reset busy", 64'(busy_a), 64'd1);
    check("mid-sweep reset rd_valid", 64'(rd_valid_a), 64'd0);
    check("mid-sweep reset wr_drop", 64'(wr_drop_a), 64'd0);
    for (int p = 0; p < 4; p++) check("mid-sweep reset rd_data", rd_data_a[p*DW +: DW], 64'd0);
    step();
    step();
    reset = 1'b0;
    count_busy(-1, na, nc);
    check("post-reset sweep cycles A", 64'(na), 64'd32);
    check("post-reset sweep cycles C", 64'(nc), 64'd24);

    // Hardwired zero entry and out-of-range addresses (dut_c, DEPTH 24).
    idle_inputs();
    set_wr(0, 0, 55);
    step();
    check("zero-reg write no drop", 64'(wr_drop_c), 64'd0);
    idle_inputs();
    set_rd(0, 0);
    step();
    check("zero-reg read data", rd_data_c[63:0], 64'd0);
    check("zero-reg read valid", 64'(rd_valid_c), 64'b0001);
    check("A addr0 holds 55", rd_data_a[63:0], 64'd55);
    idle_inputs();
    set_wr(0, 0, 77);
    set_rd(3, 0);
    step();
    check("zero-reg no bypass C", rd_data_c[255:192], 64'd0);
    check("bypass addr0 A", rd_data_a[255:192], 64'd77);
    check("zero-reg bypass no drop", 64'(wr_drop_c), 64'd0);
    idle_inputs();
    set_wr(1, 30, 'h66);
    step();
    check("out-of-range write drop C", 64'(wr_drop_c), 64'd1);
    check("in-range write no drop A", 64'(wr_drop_a), 64'd0);
    idle_inputs();
    set_rd(2, 30);
    step();
    check("out-of-range read data C", rd_data_c[191:128], 64'd0);
    check("out-of-range read valid C", 64'(rd_valid_c), 64'b0100);
    check("drop is one cycle C", 64'(wr_drop_c), 64'd0);
    check("addr30 read A", rd_data_a[191:128], 64'h66);
    idle_inputs();
    set_wr(0, 23, 'h23);
    step();
    idle_inputs();
    set_rd(1, 23);
    step();
    check("last entry C", rd_data_c[127:64], 64'h23);
    check("last entry valid C", 64'(rd_valid_c), 64'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
